// File: rtl/lbus_master.sv
`default_nettype none
// ============================================================================
// Module   : lbus_master
// Purpose  : Single-outstanding local-bus initiator driving Address/Read/Write/
//            DataIn toward the trigger-board slaves and returning one response
//            per command. Define LBUS_ACK_EN for ack-terminated cycles with timeout.
// Revision : 1.0
// ============================================================================
module lbus_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int RD_WAIT = 1,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] Address,
  output logic              Read,
  output logic              Write,
  output logic [DATA_W-1:0] DataIn,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic [7:0]        err_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [DATA_W-1:0] c_TIMEOUT_DATA = DATA_W'(32'hDEADBEEF);
  localparam logic [7:0]        c_RD_WAIT      = 8'(RD_WAIT);
  localparam logic [7:0]        c_TIMEOUT      = 8'(TIMEOUT);

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_cnt, w_cnt_nxt;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_cmd_ready, r_rsp_valid, r_rsp_err, r_read, r_write_stb;
  logic [DATA_W-1:0]   r_rsp_data, r_datain;
  logic [ADDR_W-1:0]   r_address;
  logic [7:0]          r_err_count;

  logic                w_accept, w_err_inc, w_rsp_err_nxt, w_write_sel, w_busy;
  logic [DATA_W-1:0]   w_rsp_data_nxt, w_wdata_sel;
  logic [ADDR_W-1:0]   w_addr_sel;
  logic                w_unused;

`ifdef LBUS_ACK_EN
  assign w_unused = ^{c_RD_WAIT};
`else
  assign w_unused = ^{bus_ack, c_TIMEOUT};
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_rsp_data_nxt = r_rsp_data;
    w_rsp_err_nxt  = r_rsp_err;
    w_err_inc      = 1'b0;
    w_accept       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ACC;
        end
      end
      S_ACC: begin
`ifdef LBUS_ACK_EN
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = c_TIMEOUT;
`else
        w_rsp_err_nxt = 1'b0;
        if (r_write) begin
          w_state_nxt    = S_RESP;
          w_rsp_data_nxt = '0;
        end else if (c_RD_WAIT == 8'd0) begin
          w_state_nxt    = S_RESP;
          w_rsp_data_nxt = bus_rdata;
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = c_RD_WAIT;
        end
`endif
      end
      S_WAIT: begin
`ifdef LBUS_ACK_EN
        // An ack in the final permitted cycle still wins over the timeout.
        if (bus_ack) begin
          w_state_nxt    = S_RESP;
          w_rsp_data_nxt = r_write ? '0 : bus_rdata;
          w_rsp_err_nxt  = 1'b0;
        end else if (r_cnt <= 8'd1) begin
          w_state_nxt    = S_RESP;
          w_rsp_data_nxt = c_TIMEOUT_DATA;
          w_rsp_err_nxt  = 1'b1;
          w_err_inc      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
`else
        if (r_cnt <= 8'd1) begin
          w_state_nxt    = S_RESP;
          w_rsp_data_nxt = bus_rdata;
          w_rsp_err_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Bus outputs are registered, so they are derived from the next state.
    w_write_sel = w_accept ? cmd_write : r_write;
    w_addr_sel  = w_accept ? cmd_addr  : r_addr;
    w_wdata_sel = w_accept ? cmd_wdata : r_wdata;
    w_busy      = (w_state_nxt == S_ACC) || (w_state_nxt == S_WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_address   <= '0;
      r_read      <= 1'b0;
      r_write_stb <= 1'b0;
      r_datain    <= '0;
      r_err_count <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      if (w_accept) begin
        r_write <= cmd_write;
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
      end
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      r_rsp_valid <= (w_state_nxt == S_RESP);
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_address   <= w_busy ? w_addr_sel : '0;
      r_read      <= w_busy && !w_write_sel;
      r_write_stb <= (w_state_nxt == S_ACC) && w_write_sel;
      r_datain    <= ((w_state_nxt == S_ACC) && w_write_sel) ? w_wdata_sel : '0;
      if (w_err_inc && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign Address   = r_address;
  assign Read      = r_read;
  assign Write     = r_write_stb;
  assign DataIn    = r_datain;
  assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_lbus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_lbus_master
// Purpose  : Directed vector bench for lbus_master (LBUS_ACK_EN optional).
// Revision : 1.0
// ============================================================================
module tb_lbus_master;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int RD_WAIT = 1;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] Address;
  logic              Read, Write;
  logic [DATA_W-1:0] DataIn, bus_rdata;
  logic              bus_ack;
  logic [7:0]        err_count;

  lbus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_WAIT(RD_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .Address(Address), .Read(Read), .Write(Write), .DataIn(DataIn),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .err_count(err_count)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic        w;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] v;
    int          ad;
  } vec_t;

  vec_t        vecs [6];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_errs = 0;
  logic [31:0] last_data;
  logic        last_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d);
    int i;
    i = 0;
    while (!cmd_ready && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk("issue_ready", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    @(posedge clk);
  endtask

  task automatic run(input logic w, input logic [7:0] a, input logic [31:0] d,
                     input logic [31:0] v, input int ad);
    int lat, smp, ak;
    logic to;
`ifdef LBUS_ACK_EN
    to  = (ad > TIMEOUT);
    lat = to ? 2 + TIMEOUT : 2 + ad;
    ak  = to ? -1 : 1 + ad;
    smp = w ? -1 : ak;
`else
    to  = 1'b0;
    lat = w ? 2 : 2 + RD_WAIT;
    ak  = 1;
    smp = w ? -1 : 1 + RD_WAIT;
`endif
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 1'b0;
      chk("cycle", {52'd0, rsp_valid, cmd_ready, Read, Write, Address},
          {52'd0, (k == lat), 1'b0, (!w && k < lat), (w && k == 1), ((k < lat) ? a : 8'h00)});
      if (w && k == 1) chk("datain", {32'd0, DataIn}, {32'd0, d});
      bus_rdata = (k == smp) ? v : ~v;
      bus_ack   = (k == ak);
    end
    bus_ack   = 1'b0;
    bus_rdata = ~v;
    if (to && exp_errs < 255) exp_errs++;
    last_data = to ? 32'hDEADBEEF : (w ? 32'h0 : v);
    last_err  = to;
    chk("rsp_data", {32'd0, rsp_data}, {32'd0, last_data});
    chk("rsp_err", {63'd0, rsp_err}, {63'd0, last_err});
    chk("err_count", {56'd0, err_count}, 64'(exp_errs));
  endtask

  task automatic hold_rsp(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("hold_ctl", {52'd0, rsp_valid, cmd_ready, Read, Write, Address}, {52'd0, 4'b1000, 8'h00});
      chk("hold_data", {31'd0, rsp_err, rsp_data}, {31'd0, last_err, last_data});
    end
  endtask

  task automatic free_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("free", {62'd0, rsp_valid, cmd_ready}, 64'd1);
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; bus_rdata = '0; bus_ack = 1'b0;
    vecs[0] = '{1'b1, 8'h01, 32'h0000F0F0, 32'h00000000, 1};
    vecs[1] = '{1'b0, 8'h03, 32'h00000000, 32'h0F000000, 1};
    vecs[2] = '{1'b1, 8'hFF, 32'hFFFFFFFF, 32'h00000000, 3};
    vecs[3] = '{1'b0, 8'h80, 32'h00000000, 32'hA5A5A5A5, TIMEOUT};
    vecs[4] = '{1'b0, 8'h00, 32'h00000000, 32'h00000000, 2};
    vecs[5] = '{1'b1, 8'h7E, 32'h12345678, 32'h00000000, 1};

    repeat (3) @(negedge clk);
    chk("rst_ctl", {59'd0, cmd_ready, rsp_valid, rsp_err, Read, Write}, {59'd0, 5'b10000});
    chk("rst_bus", {24'd0, Address, DataIn}, 64'd0);
    chk("rst_rsp", {24'd0, err_count, rsp_data}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {63'd0, cmd_ready}, 64'd1);

    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].w, vecs[i].a, vecs[i].d);
      run(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].v, vecs[i].ad);
      free_rsp();
    end

    // Response backpressure: everything frozen until rsp_ready.
    issue(1'b0, 8'h03, 32'h0);
    run(1'b0, 8'h03, 32'h0, 32'h0F000000, 2);
    hold_rsp(5);
    free_rsp();

    // A command offered while the response is consumed must wait a cycle.
    issue(1'b1, 8'h20, 32'hCAFEF00D);
    run(1'b1, 8'h20, 32'hCAFEF00D, 32'h0, 1);
    rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h44; cmd_wdata = '0;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("no_accept_on_consume", {60'd0, rsp_valid, cmd_ready, Read, Write}, {60'd0, 4'b0100});
    @(posedge clk);
    run(1'b0, 8'h44, 32'h0, 32'h13579BDF, 1);
    free_rsp();

    // Asynchronous reset while a read sits in WAIT.
    issue(1'b0, 8'h3C, 32'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    bus_rdata = 32'h11111111;
    @(posedge clk);
    #3;
    chk("wait_read", {55'd0, Read, Address}, {55'd0, 1'b1, 8'h3C});
    rst = 1'b1;
    #1;
    chk("rst_async", {52'd0, rsp_valid, cmd_ready, Read, Write, Address}, {52'd0, 4'b0100, 8'h00});
    @(negedge clk);
    rst = 1'b0;
    exp_errs = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst", {61'd0, rsp_valid, cmd_ready, Read}, {61'd0, 3'b010});
    end

`ifdef LBUS_ACK_EN
    issue(1'b0, 8'h10, 32'h0);
    run(1'b0, 8'h10, 32'h0, 32'h0BADF00D, TIMEOUT);
    free_rsp();
    for (int i = 0; i < 300; i++) begin
      issue(1'b0, 8'h11, 32'h0);
      run(1'b0, 8'h11, 32'h0, 32'h00000001, 999);
      free_rsp();
    end
    chk("err_sat", {56'd0, err_count}, 64'd255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
